// File: rtl/mon_exp_ctrl.sv
// mon_exp_ctrl: left-to-right square-and-multiply sequencer for a Montgomery
// product engine. It issues one engine op at a time, owns the scratchpad
// write port (host loader while idle, engine results while busy) and
// captures the final converted product.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   DRAIN  | post-reset wait so an un-reset engine can finish in-flight op
//   IDLE   | waiting for go; host loader owns the scratchpad write port
//   ISSUE  | mp_start high for one cycle
//   GUARD  | one cycle; engine still shows the previous stop, ignore it
//   WAIT   | waiting for mp_stop, then pick the next op
//   FINISH | done pulse; result valid
module mon_exp_ctrl #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 256,
    parameter int BITLEN     = 256,
    parameter int LOG_BITLEN = 8,
    parameter int MP_COUNT   = 255,
    parameter int DRAIN      = MP_COUNT + 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  go_i,
    input  logic [BITLEN-1:0]     exp_i,
    input  logic [LOG_BITLEN:0]   exp_len_i,
    input  logic                  ld_en_i,
    input  logic [ABITS-1:0]      ld_addr_i,
    input  logic [DBITS-1:0]      ld_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DBITS-1:0]      result_o,
    output logic                  mp_start_o,
    output logic [1:0]            mp_op_o,
    output logic [LOG_BITLEN:0]   mp_count_o,
    input  logic                  mp_stop_i,
    input  logic                  mp_wr_en_i,
    input  logic [ABITS-1:0]      mp_wr_addr_i,
    input  logic [DBITS-1:0]      mp_wr_data_i,
    output logic                  mem_wr_en_o,
    output logic [ABITS-1:0]      mem_wr_addr_o,
    output logic [DBITS-1:0]      mem_wr_data_o
);

    localparam int CW = $clog2(DRAIN + 1);

    localparam logic [2:0] S_DRAIN  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_GUARD  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [1:0] OP_XX = 2'd0;
    localparam logic [1:0] OP_XM = 2'd1;
    localparam logic [1:0] OP_X1 = 2'd2;

    localparam logic [LOG_BITLEN:0] LEN_MAX = (LOG_BITLEN+1)'(BITLEN);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         drain_cnt_q, drain_cnt_d;
    logic [BITLEN-1:0]     exp_q, exp_d;
    logic [LOG_BITLEN-1:0] idx_q, idx_d;
    logic [1:0]            op_q, op_d;
    logic                  done_q, done_d;
    logic [DBITS-1:0]      result_q, result_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ABITS-1:0]      mem_wr_addr_q, mem_wr_addr_d;
    logic [DBITS-1:0]      mem_wr_data_q, mem_wr_data_d;

    logic [LOG_BITLEN:0]   len_clamped;
    logic                  op_active;

    assign len_clamped = (exp_len_i > LEN_MAX) ? LEN_MAX : exp_len_i;
    assign op_active   = (state_q == S_ISSUE) || (state_q == S_GUARD) || (state_q == S_WAIT);

    // Sequencer: drain timer, go capture and next-op selection on engine stop.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        exp_d       = exp_q;
        idx_d       = idx_q;
        op_d        = op_q;
        done_d      = 1'b0;
        case (state_q)
            S_DRAIN: begin
                if (drain_cnt_q == CW'(DRAIN - 1)) begin
                    drain_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (go_i) begin
                    exp_d   = exp_i;
                    idx_d   = LOG_BITLEN'(len_clamped - (LOG_BITLEN+1)'(1));
                    op_d    = (exp_len_i == '0) ? OP_X1 : OP_XX;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (mp_stop_i) begin
                    state_d = S_ISSUE;
                    case (op_q)
                        OP_XX: begin
                            if (exp_q[idx_q]) begin
                                op_d = OP_XM;
                            end else if (idx_q == '0) begin
                                op_d = OP_X1;
                            end else begin
                                idx_d = idx_q - LOG_BITLEN'(1);
                                op_d  = OP_XX;
                            end
                        end
                        OP_XM: begin
                            if (idx_q == '0) begin
                                op_d = OP_X1;
                            end else begin
                                idx_d = idx_q - LOG_BITLEN'(1);
                                op_d  = OP_XX;
                            end
                        end
                        default: begin
                            state_d = S_FINISH;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_DRAIN;
        endcase
    end

    // Write-port mux (host in IDLE, engine while sequencing, nothing in DRAIN)
    // and capture of the converted result.
    always_comb begin
        mem_wr_en_d   = 1'b0;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        result_d      = result_q;
        if (state_q == S_IDLE) begin
            if (ld_en_i) begin
                mem_wr_en_d   = 1'b1;
                mem_wr_addr_d = ld_addr_i;
                mem_wr_data_d = ld_data_i;
            end
        end else if (state_q != S_DRAIN) begin
            if (mp_wr_en_i) begin
                mem_wr_en_d   = 1'b1;
                mem_wr_addr_d = mp_wr_addr_i;
                mem_wr_data_d = mp_wr_data_i;
            end
        end
        if (op_active && (op_q == OP_X1) && mp_wr_en_i && (mp_wr_addr_i == '0)) begin
            result_d = mp_wr_data_i;
        end
    end

    // State and output registers; reset lands in DRAIN with all outputs quiet.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_DRAIN;
            drain_cnt_q   <= '0;
            exp_q         <= '0;
            idx_q         <= '0;
            op_q          <= OP_XX;
            done_q        <= 1'b0;
            result_q      <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            exp_q         <= exp_d;
            idx_q         <= idx_d;
            op_q          <= op_d;
            done_q        <= done_d;
            result_q      <= result_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign mp_start_o    = (state_q == S_ISSUE);
    assign mp_op_o       = op_q;
    assign mp_count_o    = (LOG_BITLEN+1)'(MP_COUNT);
    assign mem_wr_en_o   = mem_wr_en_q;
    assign mem_wr_addr_o = mem_wr_addr_q;
    assign mem_wr_data_o = mem_wr_data_q;

endmodule

// File: tb/tb_mon_exp_ctrl.sv
// Bench for mon_exp_ctrl: behavioural Montgomery engine working mod 241 on a
// modelled scratchpad, with op and write scoreboards.
module tb_mon_exp_ctrl;

    localparam int  N_MOD = 241;
    localparam int  M_VAL = 3;

    logic          clk;
    logic          rst_n;
    logic          go;
    logic [255:0]  exp_v;
    logic [8:0]    exp_len;
    logic          ld_en;
    logic [7:0]    ld_addr;
    logic [255:0]  ld_data;
    logic          busy;
    logic          done;
    logic [255:0]  result;
    logic          mp_start;
    logic [1:0]    mp_op;
    logic [8:0]    mp_count;
    logic          mp_stop;
    logic          mp_wr_en;
    logic [7:0]    mp_wr_addr;
    logic [255:0]  mp_wr_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_addr;
    logic [255:0]  mem_wr_data;

    mon_exp_ctrl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .go_i          (go),
        .exp_i         (exp_v),
        .exp_len_i     (exp_len),
        .ld_en_i       (ld_en),
        .ld_addr_i     (ld_addr),
        .ld_data_i     (ld_data),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
        .mp_start_o    (mp_start),
        .mp_op_o       (mp_op),
        .mp_count_o    (mp_count),
        .mp_stop_i     (mp_stop),
        .mp_wr_en_i    (mp_wr_en),
        .mp_wr_addr_i  (mp_wr_addr),
        .mp_wr_data_i  (mp_wr_data),
        .mem_wr_en_o   (mem_wr_en),
        .mem_wr_addr_o (mem_wr_addr),
        .mem_wr_data_o (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0]   opq [$];
    logic [263:0] wq  [$];
    logic [255:0] scratch [256];
    int           n_starts;
    int           done_cnt;
    logic         drop_wr;
    longint       r_mod, r_inv, mbar;

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic longint mont(input longint a, input longint b);
        return ((a * b) % N_MOD) * r_inv % N_MOD;
    endfunction

    // Scratchpad model fed only by the DUT write port, plus write scoreboard.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            logic have;
            logic [263:0] want;
            have = (wq.size() != 0);
            chk("wr_expected", have, 1);
            if (have) begin
                want = wq.pop_front();
                chk("wr_addr_data", {mem_wr_addr, mem_wr_data}, want);
            end
            scratch[mem_wr_addr] = mem_wr_data;
        end
        if (done) done_cnt++;
    end

    // Behavioural engine: stop stays high through GUARD, write, then stop.
    initial begin
        logic [1:0] op;
        logic       have;
        longint     a, v;
        mp_stop = 1'b1; mp_wr_en = 1'b0; mp_wr_addr = '0; mp_wr_data = '0;
        forever begin
            @(posedge clk); #1;
            if (mp_start) begin
                op = mp_op;
                n_starts++;
                have = (opq.size() != 0);
                chk("op_expected", have, 1);
                if (have) chk("mp_op", op, opq.pop_front());
                @(posedge clk); #1;
                chk("start_pulse", mp_start, 0);
                chk("op_hold", mp_op, op);
                @(posedge clk); #1;
                mp_stop = 1'b0;
                @(posedge clk); #1;
                a = longint'(scratch[0][31:0]);
                case (op)
                    2'd0:    v = mont(a, a);
                    2'd1:    v = mont(a, longint'(scratch[2][31:0]));
                    default: v = mont(a, 1);
                endcase
                mp_wr_en = 1'b1; mp_wr_addr = 8'd0; mp_wr_data = 256'(v);
                if (!drop_wr) wq.push_back({8'd0, 256'(v)});
                @(posedge clk); #1;
                mp_wr_en = 1'b0;
                @(posedge clk); #1;
                mp_stop = 1'b1;
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 1);
        chk("rst_start", mp_start, 0);
        chk("rst_op", mp_op, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
    endtask

    // Called at the negedge where rst_n has just been released.
    task automatic drain_check();
        int   cnt;
        logic bad;
        cnt = 0; bad = 1'b0;
        while (busy && cnt < 1000) begin
            cnt++;
            if (mp_start || done || mem_wr_en || (result != 0) || (mp_op != 0)) bad = 1'b1;
            @(negedge clk);
        end
        chk("drain_len", cnt, 259);
        chk("drain_quiet", bad, 0);
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [255:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        wq.push_back({a, d});
        @(posedge clk); #1;
        chk("ld_lat", mem_wr_en, 1);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic load_ops();
        host_wr(8'd0, 256'(r_mod));
        host_wr(8'd2, 256'(mbar));
    endtask

    task automatic start_go(input logic [255:0] e, input logic [8:0] len,
                            output longint res, output int nops);
        int L;
        L = (len > 256) ? 256 : int'(len);
        res = 1; nops = 0;
        for (int i = L - 1; i >= 0; i--) begin
            opq.push_back(2'd0); nops++;
            res = (res * res) % N_MOD;
            if (e[i]) begin
                opq.push_back(2'd1); nops++;
                res = (res * M_VAL) % N_MOD;
            end
        end
        opq.push_back(2'd2); nops++;
        n_starts = 0; done_cnt = 0;
        @(negedge clk);
        go = 1'b1; exp_v = e; exp_len = len;
        @(posedge clk); #1;
        chk("start_lat", mp_start, 1);
        chk("busy_rise", busy, 1);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic finish_run(input longint res, input int nops);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        if (got) begin
            chk("result", result, 264'(res));
            chk("n_ops", n_starts, nops);
            chk("ops_left", opq.size(), 0);
            chk("wr_left", wq.size(), 0);
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("busy_fall", busy, 0);
            chk("done_count", done_cnt, 1);
            chk("result_hold", result, 264'(res));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint     res;
        int         nops;
        logic [255:0] e;
        rst_n = 1'b0; go = 1'b0; exp_v = '0; exp_len = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; drop_wr = 1'b0;
        for (int i = 0; i < 256; i++) scratch[i] = '0;
        r_mod = 1;
        for (int i = 0; i < 256; i++) r_mod = (r_mod * 2) % N_MOD;
        r_inv = 0;
        for (int i = 1; i < N_MOD; i++) if ((r_mod * i) % N_MOD == 1) r_inv = i;
        mbar = (M_VAL * r_mod) % N_MOD;

        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        drain_check();
        chk("mp_count", mp_count, 255);

        host_wr(8'd0, 256'd5);
        host_wr(8'd2, 256'd7);

        // exp=1011b over 4 bits with go/ld noise injected during WAIT
        load_ops();
        start_go(256'hB, 9'd4, res, nops);
        chk("model_a", res, 12);
        @(posedge clk); @(posedge clk); #2;
        go = 1'b1; exp_v = '0; ld_en = 1'b1; ld_addr = 8'd2; ld_data = 256'd99;
        @(posedge clk); #2;
        go = 1'b0; ld_en = 1'b0;
        finish_run(res, nops);

        load_ops();
        start_go(256'hB, 9'd0, res, nops);
        finish_run(res, nops);

        load_ops();
        start_go(256'hA5, 9'd8, res, nops);
        finish_run(res, nops);

        e = '0; e[255] = 1'b1; e[0] = 1'b1;
        load_ops();
        start_go(e, 9'd300, res, nops);
        finish_run(res, nops);

        // Reset while the X1 op is in WAIT; the engine's late write must be dropped.
        load_ops();
        start_go(256'h0, 9'd0, res, nops);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        drop_wr = 1'b1;
        opq.delete();
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        drain_check();
        drop_wr = 1'b0;
        chk("wr_left_rst", wq.size(), 0);

        load_ops();
        start_go(256'hB, 9'd4, res, nops);
        finish_run(res, nops);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
